ltc2145_sample_capture: RTL

Capture stage that sits directly upstream of the LTC2145 AXI4-Lite register block. It accepts dual-channel 14-bit samples from the LTC2145 ADC data path, which are already synchronous to ACLK. It optionally converts them from offset binary to two's complement and decimates them by a programmable ratio. It packs each kept channel pair into a 32-bit word and buffers it in a first-word-fall-through FIFO that the register block pops on AXI reads.

---
 rtl/ltc2145_sample_capture.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ltc2145_sample_capture.sv
// ltc2145_sample_capture
// Takes dual-channel ADC samples and optionally converts each one from
// offset binary to two's complement. It then decimates the stream, packs
// each kept pair into a 32-bit word, and queues the words in a
// first-word-fall-through FIFO that the AXI register block drains.

module ltc2145_sample_capture #(
  parameter int DATA_WIDTH = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int DEC_WIDTH  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          adc_valid,
  input  logic [DATA_WIDTH-1:0]         adc_ch_a,
  input  logic [DATA_WIDTH-1:0]         adc_ch_b,
  input  logic                          cfg_enable,
  input  logic                          cfg_twos_comp,
  input  logic [DEC_WIDTH-1:0]          cfg_decim,
  input  logic                          cfg_clear,
  input  logic                          rd_pop,
  output logic [31:0]                   rd_data,
  output logic                          rd_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [31:0]                   sample_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_VAL = FIFO_DEPTH[AW:0];

  logic [DEC_WIDTH-1:0] dec_cnt;
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [31:0]          mem [FIFO_DEPTH];

  logic                 keep;
  logic                 full;
  logic                 empty;
  logic                 do_pop;
  logic                 do_push;
  logic                 drop;
  logic [AW:0]          level;
  logic [AW:0]          level_after_pop;
  logic [AW:0]          next_rd_ptr;
  logic [AW:0]          next_level;
  logic [31:0]          push_word;
  logic [31:0]          head_next;

  // A sample is extended to 16 bits. In two's complement mode the MSB is
  // inverted, which subtracts mid-scale from the code, and the result is then
  // sign-extended. Otherwise the raw code is zero-extended.
  function automatic logic [15:0] extend(input logic [DATA_WIDTH-1:0] s, input logic twos);
    logic [15:0] r;
    if (twos)
      r = {{(16-DATA_WIDTH){~s[DATA_WIDTH-1]}}, ~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
    else
      r = {{(16-DATA_WIDTH){1'b0}}, s};
    return r;
  endfunction

  // Push/pop qualification and next-head selection for the FIFO.
  always_comb begin
    level           = wr_ptr - rd_ptr;
    full            = (level == DEPTH_VAL);
    empty           = (level == '0);
    keep            = adc_valid && cfg_enable && (dec_cnt == '0);
    do_pop          = rd_pop && !empty && !cfg_clear;
    do_push         = keep && (!full || do_pop) && !cfg_clear;
    drop            = keep && full && !do_pop && !cfg_clear;
    push_word       = {extend(adc_ch_b, cfg_twos_comp), extend(adc_ch_a, cfg_twos_comp)};
    level_after_pop = level - {{AW{1'b0}}, do_pop};
    next_rd_ptr     = rd_ptr + {{AW{1'b0}}, do_pop};
    next_level      = level_after_pop + {{AW{1'b0}}, do_push};
    if (do_push && (level_after_pop == '0))
      head_next = push_word;
    else
      head_next = mem[next_rd_ptr[AW-1:0]];
  end

  assign fifo_level = level;
  assign rd_empty   = empty;

  // The decimation counter reloads on each kept sample and is parked at zero
  // while capture is disabled, so the first sample after enabling is kept.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      dec_cnt <= '0;
    else if (cfg_clear || !cfg_enable)
      dec_cnt <= '0;
    else if (adc_valid) begin
      if (dec_cnt == '0)
        dec_cnt <= cfg_decim;
      else
        dec_cnt <= dec_cnt - 1'b1;
    end
  end

  // FIFO storage. It needs no reset because the pointers define validity.
  always_ff @(posedge ACLK) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // Pointers, the sticky overflow flag and the accepted-word counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else if (cfg_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (do_push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  // The head register presents the next head word right after the edge.
  // It holds its last value whenever the FIFO goes empty or is cleared.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      rd_data <= '0;
    else if (!cfg_clear && (next_level != '0))
      rd_data <= head_next;
  end

endmodule
